// File: rtl/sram_read_scheduler.sv
// Round-robin read scheduler for per-queue SRAM FIFOs: grants one queue at a time and
// issues reads with a bounded number outstanding, switching queues only at packet boundaries.
module sram_read_scheduler #(
    parameter int unsigned NUM_QUEUES      = 4,
    parameter int unsigned QUEUE_ID_WIDTH  = 2,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned OUTST_WIDTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_QUEUES-1:0]     queue_enable,
    input  logic [NUM_QUEUES-1:0]     read_empty,
    input  logic                      read_burst_state,
    input  logic                      out_nearly_full,
    input  logic                      read_data_valid,
    input  logic [QUEUE_ID_WIDTH-1:0] read_data_queue_id,
    input  logic                      read_data_last,
    output logic [QUEUE_ID_WIDTH-1:0] read_queue_id,
    output logic                      read_data_ready,
    output logic                      busy,
    output logic [31:0]               pkt_count,
    output logic                      err_sticky
);

    typedef enum logic [1:0] {StIdle, StSelect, StIssue, StDrain} state_e;

    localparam logic [OUTST_WIDTH-1:0]    MaxOutst  = OUTST_WIDTH'(MAX_OUTSTANDING);
    localparam logic [QUEUE_ID_WIDTH-1:0] LastQueue = QUEUE_ID_WIDTH'(NUM_QUEUES - 1);

    state_e                    state_q, state_d;
    logic [QUEUE_ID_WIDTH-1:0] cur_queue_q, cur_queue_d;
    logic [QUEUE_ID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [OUTST_WIDTH-1:0]    outstanding_q, outstanding_d;
    logic                      mid_pkt_q, mid_pkt_d;
    logic [31:0]               pkt_count_q;
    logic                      err_q;

    logic [NUM_QUEUES-1:0]     eligible;
    logic                      grant_valid;
    logic [QUEUE_ID_WIDTH-1:0] grant_id;
    logic                      cur_empty;
    logic                      ret_last_match;
    logic                      issue;

    function automatic logic [QUEUE_ID_WIDTH-1:0] wrap_id(
        input logic [QUEUE_ID_WIDTH-1:0] base,
        input int unsigned               off
    );
        return QUEUE_ID_WIDTH'((32'(base) + off) % NUM_QUEUES);
    endfunction

    assign eligible       = queue_enable & ~read_empty;
    assign cur_empty      = read_empty[cur_queue_q];
    assign ret_last_match = read_data_valid & read_data_last & (read_data_queue_id == cur_queue_q);

    // First eligible queue strictly after the previous grant, wrapping around.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int unsigned i = 1; i <= NUM_QUEUES; i++) begin
            if (!grant_valid && eligible[wrap_id(last_grant_q, i)]) begin
                grant_valid = 1'b1;
                grant_id    = wrap_id(last_grant_q, i);
            end
        end
    end

    // The cycle carrying the packet's last word is already the hand-off to DRAIN: no issue.
    assign issue = (state_q == StIssue) && !read_burst_state && (outstanding_q < MaxOutst) &&
                   !out_nearly_full && !cur_empty && !ret_last_match;

    always_comb begin
        state_d      = state_q;
        cur_queue_d  = cur_queue_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (enable) state_d = StSelect;
            end
            StSelect: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (grant_valid) begin
                    cur_queue_d  = grant_id;
                    last_grant_d = grant_id;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (ret_last_match) begin
                    state_d = StDrain;
                end else if (cur_empty && (outstanding_q == '0) && !mid_pkt_q) begin
                    state_d = StSelect;
                end
            end
            StDrain: begin
                // Over-issued words of the next packet keep us on this queue until it ends.
                if (outstanding_q == '0) state_d = mid_pkt_q ? StIssue : StSelect;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue && !read_data_valid) begin
            outstanding_d = outstanding_q + OUTST_WIDTH'(1);
        end else if (!issue && read_data_valid && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OUTST_WIDTH'(1);
        end
        mid_pkt_d = read_data_valid ? !read_data_last : mid_pkt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cur_queue_q   <= '0;
            last_grant_q  <= LastQueue;
            outstanding_q <= '0;
            mid_pkt_q     <= 1'b0;
            pkt_count_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_queue_q   <= cur_queue_d;
            last_grant_q  <= last_grant_d;
            outstanding_q <= outstanding_d;
            mid_pkt_q     <= mid_pkt_d;
            if (read_data_valid && read_data_last) pkt_count_q <= pkt_count_q + 32'd1;
            if (read_data_valid && ((outstanding_q == '0) || (read_data_queue_id != cur_queue_q))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign read_queue_id   = cur_queue_q;
    assign read_data_ready = issue;
    assign busy            = (state_q != StIdle);
    assign pkt_count       = pkt_count_q;
    assign err_sticky      = err_q;

endmodule

// File: tb/tb_sram_read_scheduler.sv
// Directed bench for sram_read_scheduler: round-robin with a delayed-return memory model,
// outstanding limit, stall inputs, over-issue drain, queue exhaustion and reset abandonment.
module tb_sram_read_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  queue_enable = '0;
    logic [3:0]  read_empty = 4'b1111;
    logic        read_burst_state = 1'b0;
    logic        out_nearly_full = 1'b0;
    logic        read_data_valid = 1'b0;
    logic [1:0]  read_data_queue_id = '0;
    logic        read_data_last = 1'b0;
    logic [1:0]  read_queue_id;
    logic        read_data_ready;
    logic        busy;
    logic [31:0] pkt_count;
    logic        err_sticky;

    always #5 clk = ~clk;

    sram_read_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .queue_enable       (queue_enable),
        .read_empty         (read_empty),
        .read_burst_state   (read_burst_state),
        .out_nearly_full    (out_nearly_full),
        .read_data_valid    (read_data_valid),
        .read_data_queue_id (read_data_queue_id),
        .read_data_last     (read_data_last),
        .read_queue_id      (read_queue_id),
        .read_data_ready    (read_data_ready),
        .busy               (busy),
        .pkt_count          (pkt_count),
        .err_sticky         (err_sticky)
    );

    typedef struct {
        int         due;
        logic [1:0] q;
        logic       last;
    } ret_t;

    int   checks = 0;
    int   passes = 0;

    // Memory/FIFO environment, active only while auto_mem is set.
    bit   auto_mem = 1'b0;
    int   delay = 2;
    int   cyc = 0;
    int   words_left[4];
    int   word_idx[4];
    ret_t pipe[$];
    int   glog[$];
    int   tally = 0;
    int   issues = 0;
    int   first_ret_issues = -1;
    int   viol = 0;
    int   ileave = 0;
    bit   refill_pending = 1'b0;
    bit   have_prev = 1'b0;
    logic prev_last = 1'b0;
    logic [1:0] prev_q = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        ret_t r;
        @(negedge clk);
        if (auto_mem) begin
            if (read_data_valid) begin
                if (first_ret_issues < 0) first_ret_issues = issues;
                if (have_prev && !prev_last && read_data_queue_id != prev_q) ileave++;
                have_prev = 1'b1;
                prev_last = read_data_last;
                prev_q    = read_data_queue_id;
            end
            if (read_data_ready) begin
                if (tally >= 8) viol++;
                if (glog.size() == 0 || glog[glog.size()-1] != int'(read_queue_id)) begin
                    glog.push_back(int'(read_queue_id));
                end
                r.due  = cyc + delay;
                r.q    = read_queue_id;
                r.last = (word_idx[read_queue_id] % 3) == 2;
                pipe.push_back(r);
                word_idx[read_queue_id]++;
                words_left[read_queue_id]--;
                issues++;
            end
            tally = tally + (read_data_ready ? 1 : 0) - (read_data_valid ? 1 : 0);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (auto_mem) begin
            if (refill_pending && glog.size() >= 2) begin
                words_left[0] += 3;
                refill_pending = 1'b0;
            end
            read_data_valid    = 1'b0;
            read_data_last     = 1'b0;
            read_data_queue_id = '0;
            if (pipe.size() > 0 && pipe[0].due == cyc) begin
                r = pipe.pop_front();
                read_data_valid    = 1'b1;
                read_data_queue_id = r.q;
                read_data_last     = r.last;
            end
            for (int q = 0; q < 4; q++) read_empty[q] = (words_left[q] == 0);
        end
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        enable             = 1'b0;
        read_data_valid    = 1'b0;
        read_data_last     = 1'b0;
        read_data_queue_id = '0;
        read_burst_state   = 1'b0;
        out_nearly_full    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_g[5];
        int g;
        exp_g = '{0, 1, 2, 3, 0};

        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", read_data_ready, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_queue_id", read_queue_id, 0);

        // Round robin over four one-packet queues; queue 0 refilled once queue 1 is granted.
        for (int q = 0; q < 4; q++) begin
            words_left[q] = 3;
            word_idx[q]   = 0;
        end
        read_empty     = 4'b0000;
        queue_enable   = 4'b1111;
        delay          = 2;
        refill_pending = 1'b1;
        auto_mem       = 1'b1;
        enable         = 1'b1;
        for (int n = 0; n < 300 && pkt_count != 32'd5; n++) tick();
        chk("rr_pkt_count", pkt_count, 5);
        chk("rr_grant_count", glog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            g = (i < glog.size()) ? glog[i] : -1;
            chk($sformatf("rr_grant_%0d", i), 32'(g), 32'(exp_g[i]));
        end
        repeat (4) tick();
        chk("rr_no_interleave", ileave, 0);
        chk("rr_select_busy", busy, 1);
        chk("rr_select_ready", read_data_ready, 0);
        chk("rr_no_err", err_sticky, 0);
        enable = 1'b0;
        tick();
        chk("rr_idle", busy, 0);

        // Queue 1 only, slow memory: issue stops at eight outstanding.
        words_left       = '{0, 40, 0, 0};
        read_empty       = 4'b1101;
        queue_enable     = 4'b0010;
        delay            = 20;
        tally            = 0;
        issues           = 0;
        first_ret_issues = -1;
        viol             = 0;
        have_prev        = 1'b0;
        enable           = 1'b1;
        repeat (60) tick();
        chk("lim_issues_before_return", 32'(first_ret_issues), 8);
        chk("lim_no_issue_at_max", viol, 0);
        chk("lim_no_err", err_sticky, 0);
        auto_mem = 1'b0;
        do_reset();
        pipe.delete();
        chk("lim_reset_busy", busy, 0);
        chk("lim_reset_pkt_count", pkt_count, 0);

        // Coincident issue/return at five outstanding, stall inputs, then reset mid-flight.
        queue_enable = 4'b0001;
        read_empty   = 4'b1110;
        enable       = 1'b1;
        #1;
        chk("c_idle_busy", busy, 0);
        tick();
        chk("c_select_busy", busy, 1);
        chk("c_select_ready", read_data_ready, 0);
        tick();
        chk("c_issue_ready", read_data_ready, 1);
        chk("c_issue_qid", read_queue_id, 0);
        repeat (5) tick();
        read_data_valid    = 1'b1;
        read_data_queue_id = 2'd0;
        read_data_last     = 1'b0;
        #1;
        chk("c_issue_with_return", read_data_ready, 1);
        tick();
        read_data_valid  = 1'b0;
        read_burst_state = 1'b1;
        #1;
        chk("c_burst_blocks", read_data_ready, 0);
        tick();
        read_burst_state = 1'b0;
        #1;
        chk("c_resume", read_data_ready, 1);
        tick();
        out_nearly_full = 1'b1;
        #1;
        chk("c_nearly_full_blocks", read_data_ready, 0);
        out_nearly_full = 1'b0;
        #1;
        tick();
        chk("c_at_seven", read_data_ready, 1);
        tick();
        chk("c_at_max_blocks", read_data_ready, 0);
        out_nearly_full = 1'b1;
        read_data_valid = 1'b1;
        repeat (5) tick();
        read_data_valid = 1'b0;
        reset           = 1'b1;
        enable          = 1'b0;
        tick();
        reset           = 1'b0;
        out_nearly_full = 1'b0;
        #1;
        chk("c_reset_busy", busy, 0);
        chk("c_reset_ready", read_data_ready, 0);
        chk("c_reset_err", err_sticky, 0);
        read_data_valid = 1'b1;
        read_data_last  = 1'b0;
        tick();
        chk("c_late_return_err", err_sticky, 1);
        tick();
        read_data_last = 1'b1;
        tick();
        read_data_valid = 1'b0;
        read_data_last  = 1'b0;
        #1;
        chk("c_late_err_sticky", err_sticky, 1);
        chk("c_late_pkt_count", pkt_count, 1);
        chk("c_late_idle", busy, 0);
        enable = 1'b1;
        tick();
        tick();
        chk("c_outstanding_saturated", read_data_ready, 1);
        do_reset();

        // Over-issue: words 3-4 of the next packet in flight when packet 0 ends.
        queue_enable = 4'b0001;
        read_empty   = 4'b1110;
        enable       = 1'b1;
        tick();
        tick();
        chk("d_issue_ready", read_data_ready, 1);
        tick();
        enable = 1'b0;
        #1;
        chk("d_enable_ignored_busy", busy, 1);
        chk("d_enable_ignored_ready", read_data_ready, 1);
        repeat (4) tick();
        out_nearly_full    = 1'b1;
        read_data_valid    = 1'b1;
        read_data_queue_id = 2'd0;
        read_data_last     = 1'b0;
        tick();
        tick();
        read_data_last = 1'b1;
        tick();
        out_nearly_full = 1'b0;
        read_data_last  = 1'b0;
        #1;
        chk("d_drain_no_issue", read_data_ready, 0);
        chk("d_drain_busy", busy, 1);
        tick();
        chk("d_drain_wait", read_data_ready, 0);
        tick();
        read_data_valid = 1'b0;
        #1;
        chk("d_drain_empty", read_data_ready, 0);
        tick();
        chk("d_reissue_same_queue", read_data_ready, 1);
        chk("d_reissue_qid", read_queue_id, 0);
        tick();
        read_data_valid = 1'b1;
        read_data_last  = 1'b1;
        #1;
        chk("d_no_issue_on_last", read_data_ready, 0);
        tick();
        read_data_valid = 1'b0;
        read_data_last  = 1'b0;
        read_empty      = 4'b1111;
        #1;
        chk("d_pkt_count", pkt_count, 2);
        chk("d_second_drain_busy", busy, 1);
        tick();
        chk("d_select_busy", busy, 1);
        chk("d_select_ready", read_data_ready, 0);
        tick();
        chk("d_idle", busy, 0);
        do_reset();

        // Single eligible queue 2 empties right after its grant.
        queue_enable = 4'b0100;
        read_empty   = 4'b1011;
        enable       = 1'b1;
        tick();
        tick();
        read_empty = 4'b1111;
        #1;
        chk("e_grant_qid", read_queue_id, 2);
        chk("e_empty_ready", read_data_ready, 0);
        chk("e_issue_busy", busy, 1);
        tick();
        chk("e_select_busy", busy, 1);
        chk("e_select_ready", read_data_ready, 0);
        tick();
        read_empty = 4'b1011;
        enable     = 1'b0;
        #1;
        chk("e_still_select", read_data_ready, 0);
        tick();
        chk("e_idle", busy, 0);
        do_reset();

        // Return tagged with the wrong queue.
        queue_enable = 4'b0001;
        read_empty   = 4'b1110;
        enable       = 1'b1;
        tick();
        tick();
        tick();
        out_nearly_full    = 1'b1;
        read_data_valid    = 1'b1;
        read_data_queue_id = 2'd1;
        read_data_last     = 1'b0;
        #1;
        chk("f_err_before", err_sticky, 0);
        tick();
        read_data_valid = 1'b0;
        #1;
        chk("f_err_qid_mismatch", err_sticky, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
